// File: rtl/input_port.sv
// Synchronised, debounced input peripheral: samples raw pins through a two-flop
// synchroniser, accepts a value once it has been stable long enough, and drives it onto the bus.
module input_port #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    input  logic             out_en,
    output logic [15:0]      out,
    output logic             pending
);

    localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] value;
    logic [7:0]       cnt;
    logic             accept;

    // A stable candidate that differs from the held value is taken this edge
    assign accept = (sync2 == cand) && (cnt == CNT_MAX) && (cand != value);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            cand    <= '0;
            value   <= '0;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
            if (accept) begin
                value <= cand;
            end
            // A fresh acceptance wins over a simultaneous read acknowledge
            if (accept) begin
                pending <= 1'b1;
            end else if (out_en) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        out = 16'h0000;
        if (out_en) begin
            out[15]          = pending;
            out[WIDTH-1:0]   = value;
        end
    end

endmodule

// File: tb/tb_input_port.sv
// Randomised and directed bench for input_port; both an 8-bit/16-cycle and a
// 4-bit/2-cycle instance are checked against a pin-history reference model.
module tb_input_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pins8;
    logic [3:0]  pins4;
    logic        oe;
    logic [15:0] out8;
    logic [15:0] out4;
    logic        pend8;
    logic        pend4;

    int checks = 0;
    int errors = 0;

    // Model: history of sampled pins, accepted value and pending flag per instance
    int         q8[$];
    int         q4[$];
    logic [7:0] mv8 = '0;
    logic [3:0] mv4 = '0;
    logic       mp8 = 1'b0;
    logic       mp4 = 1'b0;

    assign pins4 = pins8[3:0];

    always #5 clk = ~clk;

    input_port #(.WIDTH(8), .DEB_CYCLES(16)) dut8 (
        .clk(clk), .rst(rst), .pins(pins8), .out_en(oe), .out(out8), .pending(pend8)
    );

    input_port #(.WIDTH(4), .DEB_CYCLES(2)) dut4 (
        .clk(clk), .rst(rst), .pins(pins4), .out_en(oe), .out(out4), .pending(pend4)
    );

    // Returns the synchronised value if the pins sampled 2..2+d edges ago all agree, else -1
    function automatic int windowValue(input int h[$], input int d);
        int w;
        int n;
        n = h.size();
        if (n < d + 2) return -1;
        w = h[n-2];
        for (int k = n - 2 - d; k <= n - 2; k++)
            if (h[k] != w) return -1;
        return w;
    endfunction

    task automatic modelEdge(input logic [7:0] p, input logic o, input logic r);
        int w8;
        int w4;
        if (r) begin
            q8 = {-1, 0, 0, 0};
            q4 = {-1, 0, 0, 0};
            mv8 = '0; mv4 = '0; mp8 = 1'b0; mp4 = 1'b0;
        end else begin
            w8 = windowValue(q8, 16);
            w4 = windowValue(q4, 2);
            q8.push_back(int'(p));
            q4.push_back(int'(p[3:0]));
            while (q8.size() > 40) void'(q8.pop_front());
            while (q4.size() > 40) void'(q4.pop_front());
            if (w8 >= 0 && w8 != int'(mv8)) begin
                mv8 = 8'(w8); mp8 = 1'b1;
            end else if (o) mp8 = 1'b0;
            if (w4 >= 0 && w4 != int'(mv4)) begin
                mv4 = 4'(w4); mp4 = 1'b1;
            end else if (o) mp4 = 1'b0;
        end
    endtask

    task automatic checkConst(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [15:0] e8;
        logic [15:0] e4;
        e8 = oe ? {mp8, 7'b0, mv8} : 16'h0000;
        e4 = oe ? {mp4, 11'b0, mv4} : 16'h0000;
        checkConst("out8", out8, e8);
        checkConst("pend8", {15'b0, pend8}, {15'b0, mp8});
        checkConst("out4", out4, e4);
        checkConst("pend4", {15'b0, pend4}, {15'b0, mp4});
    endtask

    // Drive one cycle: check outputs mid-cycle, clock, then advance the model
    task automatic applyStimulus(input logic [7:0] p, input logic o, input logic r);
        pins8 = p; oe = o; rst = r;
        #4;
        if (!r) checkOutput();
        @(posedge clk);
        modelEdge(p, o, r);
        #1;
    endtask

    initial begin
        int lat;
        logic [7:0] pv;
        int hold;

        pins8 = '0; oe = 1'b0; rst = 1'b1;
        @(posedge clk); modelEdge(8'h00, 1'b0, 1'b1); #1;
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkConst("rst_pend8", {15'b0, pend8}, 16'h0000);
        checkConst("rst_pend4", {15'b0, pend4}, 16'h0000);
        oe = 1'b1; #1;
        checkConst("rst_out8", out8, 16'h0000);
        checkConst("rst_out4", out4, 16'h0000);
        oe = 1'b0;

        // Latency: pending low through edge k+17, high at k+18
        for (int i = 0; i < 18; i++) applyStimulus(8'hA5, 1'b0, 1'b0);
        checkConst("a5_k17_pend", {15'b0, pend8}, 16'h0000);
        applyStimulus(8'hA5, 1'b0, 1'b0);
        checkConst("a5_k18_pend", {15'b0, pend8}, 16'h0001);

        oe = 1'b1; #1;
        checkConst("read1_out", out8, 16'h80A5);
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkConst("read1_clr", {15'b0, pend8}, 16'h0000);
        oe = 1'b1; #1;
        checkConst("read2_out", out8, 16'h00A5);
        applyStimulus(8'hA5, 1'b1, 1'b0);
        oe = 1'b0; #1;
        checkConst("idle_out", out8, 16'h0000);

        // Short glitch never reaches the accepted value
        for (int i = 0; i < 10; i++) applyStimulus(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) applyStimulus(8'hA5, 1'b0, 1'b0);
        oe = 1'b1; #1;
        checkConst("glitch_out", out8, 16'h00A5);
        applyStimulus(8'hA5, 1'b1, 1'b0);

        // Bounce then hold: acceptance 18 edges after the final transition
        for (int i = 0; i < 100; i++) applyStimulus(((i / 5) % 2 == 0) ? 8'h01 : 8'h00, 1'b1, 1'b0);
        lat = 99;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'h01, 1'b0, 1'b0);
            if (pend8 === 1'b1) begin lat = i; break; end
        end
        checkConst("bounce_lat", 16'(lat), 16'd18);
        applyStimulus(8'h01, 1'b1, 1'b0);

        // Read on the accepting edge: old data shown, pending ends set
        for (int i = 0; i < 18; i++) applyStimulus(8'h3C, 1'b0, 1'b0);
        oe = 1'b1; #1;
        checkConst("simul_out", out8, 16'h0001);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        checkConst("simul_pend", {15'b0, pend8}, 16'h0001);
        oe = 1'b1; #1;
        checkConst("simul_after", out8, 16'h803C);
        applyStimulus(8'h3C, 1'b1, 1'b0);

        // Reset mid-debounce discards the candidate, then re-accepts after release
        for (int i = 0; i < 10; i++) applyStimulus(8'h77, 1'b0, 1'b0);
        applyStimulus(8'h77, 1'b0, 1'b1);
        oe = 1'b1; #1;
        checkConst("midrst_out", out8, 16'h0000);
        lat = 99;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'h77, 1'b0, 1'b0);
            if (pend8 === 1'b1) begin lat = i; break; end
        end
        checkConst("midrst_lat", 16'(lat), 16'd18);

        // Narrow instance: 4'h9 accepted at edge k+4
        for (int i = 0; i < 6; i++) applyStimulus(8'h70, 1'b1, 1'b0);
        lat = 99;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'h79, 1'b0, 1'b0);
            if (pend4 === 1'b1) begin lat = i; break; end
        end
        checkConst("w4_lat", 16'(lat), 16'd4);
        oe = 1'b1; #1;
        checkConst("w4_out", out4, 16'h8009);
        applyStimulus(8'h79, 1'b1, 1'b0);

        // Random segments with random reads and occasional resets
        pv = 8'h79;
        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 2) != 0) pv = 8'($urandom());
            hold = $urandom_range(1, 24);
            for (int i = 0; i < hold; i++)
                applyStimulus(pv, ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_port.md
# input_port

Synchronised, debounced 8-bit input peripheral for tiny16. It is the read-side counterpart of the display block: `display` latches a bus value onto the output pins, while `input_port` samples the raw `IN` pins and drives them onto the bus when the controller issues a read. It sits beside `display` at the top level. Its `out`/`out_en` pair feeds the bus multiplexer like the other bus sources. A sticky `pending` flag tells software when a new debounced value is available.

## Interface
- `WIDTH`, 8: number of input pins; 1..8.
- `DEB_CYCLES`, 16: consecutive stable synchronised cycles required before a new pin value is accepted; 2..255.

- `clk`  in  1  system clock (`clk_1mhz` at top level).
- `rst`  in  1  reset. One clock domain; reset is synchronous and active-high.
- `pins`  in  WIDTH  raw asynchronous input pins (top-level `IN`).
- `out_en`  in  1  read strobe from the controller; drives `out` onto the bus and acknowledges `pending`.
- `out`  out  16  bus data: `{pending, 7'b0, zero-extended value}` when `out_en=1`; `16'h0000` otherwise.
- `pending`  out  1  a new debounced value has been accepted and not yet read.

## Operation
- Registers:
  - `sync1`, `sync2` [WIDTH]: two-flop synchroniser, `sync1<=pins`, `sync2<=sync1`.
  - `cand` [WIDTH]: candidate value under debounce.
  - `cnt` [8]: stability counter.
  - `value` [WIDTH]: accepted value.
  - `pending`: new-value flag.
- Every edge, in priority order:
  - If `sync2 != cand`: `cand<=sync2`, `cnt<=0`.
  - Else if `cnt != DEB_CYCLES-1`: `cnt<=cnt+1`.
  - Else (stable): `cnt` holds (saturates). If `cand != value`: `value<=cand`, `pending<=1`.
- Read: `out_en=1` at an edge clears `pending`, unless that same edge accepts a new value, in which case `pending` ends at 1.
- `out` is combinational from registers, gated by `out_en`. `out[15]=pending`, `out[14:WIDTH]=0`, `out[WIDTH-1:0]=value`.
- The value read is the one held before the edge. Reading with `pending=0` returns the current `value` and is legal.
- A glitch shorter than `DEB_CYCLES` synchronised cycles restarts `cnt` and never changes `value`.
- A return to the already-accepted value after bouncing produces no update and does not set `pending`.
- Reset:
  - `sync1`, `sync2`, `cand`, `value`, `cnt` = 0; `pending=0`; `out=16'h0000`.
  - Reset asserted mid-debounce discards the candidate.
  - Nonzero pins held through reset are accepted `DEB_CYCLES+2` edges after reset release and set `pending`.

## Timing
- `pins` changes before edge k and then stays stable:
  - `sync1` at k, `sync2` at k+1.
  - `cand` at k+2 with `cnt=0`.
  - `cnt` reaches `DEB_CYCLES-1` at k+1+DEB_CYCLES.
  - `value` and `pending` update at edge k+2+DEB_CYCLES.
  - With the default of 16, latency is 18 edges.
- `out` is valid in the same cycle `out_en` is high (zero-latency bus source). The controller samples the bus at the following edge.
- `pending` clears at the edge on which `out_en` is sampled high. It is visible low from the next cycle.
- Back-to-back reads are allowed. The second read returns `pending=0` unless a new value was accepted in between.
- Changes that arrive faster than `DEB_CYCLES+2` apart can leave intermediate values unseen. Only the last value that stays stable is accepted.

## Test plan
- Reset with `pins=8'h00`, then step `pins` to `8'hA5` and hold: `pending` and `value` stay 0 through edge k+17 and become 1/`8'hA5` at edge k+18. A read then gives `out=16'h80A5`.
- Read at the cycle after acceptance: `out=16'h80A5` during `out_en`, and `pending=0` after the edge. A second read gives `out=16'h00A5`, and `out=16'h0000` whenever `out_en=0`.
- Glitch: with `value=8'hA5`, drive `8'hFF` for 10 cycles and then back to `8'hA5`: `value` stays `8'hA5` and `pending` stays 0. Bouncing `8'h01`/`8'h00` every 5 cycles for 100 cycles and then holding `8'h01` gives acceptance exactly 18 edges after the final transition.
- Simultaneous read and accept: assert `out_en` on the edge that accepts `8'h3C`: `out` shows the old value with the old `pending` during that cycle, and `pending=1` with `value=8'h3C` afterwards.
- Reset mid-debounce: drive `8'h77` and assert `rst` 10 edges later: all state returns to 0 at the reset edge. With `8'h77` still applied, acceptance and `pending=1` occur 18 edges after `rst` deasserts.
- Parameters `WIDTH=4`, `DEB_CYCLES=2`: pin change to `4'h9` is accepted at edge k+4, `out=16'h8009`, and `out[14:4]` is always 0.
